// File: rtl/wmem_stat_upd.sv
`default_nettype none
// ============================================================================
//  Module   : wmem_stat_upd
//  Purpose  : Read-modify-write statistics engine for the wide memory's
//             application port. Zero-fills the memory after reset, then
//             accepts one counter update per cycle. Each update reads the
//             entry, adds the increment (or clears it), and writes the result
//             back four cycles later. A four-entry write history forwards
//             values still in flight, so back-to-back updates to one entry
//             never lose a count.
//  Ports    : clk, rstn (async, active low)
//             req_valid/req_ready/req_addr/req_inc/req_clr - update request
//             rsp_valid/rsp_data     - pre-update counter value
//             app_mem_rd/raddr/ack/rdata - memory read port (3-cycle latency)
//             app_mem_wr/waddr/wdata     - memory write port
//             init_done              - zero-fill complete
//  Options  : WMEM_STAT_SAT_EN - sums saturate at all-ones instead of wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module wmem_stat_upd #(
    parameter int WIDTH       = 40,
    parameter int DEPTH_NBITS = 10,
    parameter int INC_NBITS   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DEPTH_NBITS-1:0] req_addr,
    input  logic [INC_NBITS-1:0]   req_inc,
    input  logic                   req_clr,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   app_mem_rd,
    output logic [DEPTH_NBITS-1:0] app_mem_raddr,
    input  logic                   app_mem_ack,
    input  logic [WIDTH-1:0]       app_mem_rdata,
    output logic                   app_mem_wr,
    output logic [DEPTH_NBITS-1:0] app_mem_waddr,
    output logic [WIDTH-1:0]       app_mem_wdata,
    output logic                   init_done
);

    localparam logic [DEPTH_NBITS-1:0] c_last_addr = '1;
    localparam int                     c_hist      = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [DEPTH_NBITS-1:0]  r_fill_addr;
    logic                    r_fill_wr;
    logic [DEPTH_NBITS-1:0]  r_fill_waddr;
    logic                    r_init_done;

    // Request pipeline C1..C3: index 2 is aligned with the memory ack.
    logic [2:0]                    r_pv;
    logic [2:0][DEPTH_NBITS-1:0]   r_pa;
    logic [2:0][INC_NBITS-1:0]     r_pi;
    logic [2:0]                    r_pc;

    // Write history: entry 0 is the write-stage register driving the port.
    logic [c_hist-1:0]                   r_hv;
    logic [c_hist-1:0][DEPTH_NBITS-1:0]  r_ha;
    logic [c_hist-1:0][WIDTH-1:0]        r_hd;

    logic                    r_rsp_valid;
    logic [WIDTH-1:0]        r_rsp_data;

    logic                    w_accept;
    logic [WIDTH-1:0]        w_base;
    logic [WIDTH-1:0]        w_inc_res;
    logic [WIDTH-1:0]        w_new;

    assign w_accept      = req_valid & r_init_done;
    assign req_ready     = r_init_done;
    assign init_done     = r_init_done;

    // Read issue is combinational so the ack lands exactly on C3.
    assign app_mem_rd    = w_accept;
    assign app_mem_raddr = w_accept ? req_addr : '0;

    // Fill writes and update writes never overlap: updates are only
    // accepted once the fill has finished.
    assign app_mem_wr    = r_fill_wr | r_hv[0];
    assign app_mem_waddr = r_fill_wr ? r_fill_waddr : r_ha[0];
    assign app_mem_wdata = r_fill_wr ? '0 : r_hd[0];

    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;

    // Youngest matching history entry wins; scanning oldest-first lets the
    // later (younger) assignment override.
    always_comb begin
        w_base = app_mem_rdata;
        for (int i = c_hist - 1; i >= 0; i--) begin
            if (r_hv[i] && (r_ha[i] == r_pa[2])) begin
                w_base = r_hd[i];
            end
        end
    end

`ifdef WMEM_STAT_SAT_EN
    logic [WIDTH:0] w_sum;
    assign w_sum     = {1'b0, w_base} + (WIDTH+1)'(r_pi[2]);
    assign w_inc_res = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
    assign w_inc_res = w_base + WIDTH'(r_pi[2]);
`endif

    assign w_new = r_pc[2] ? '0 : w_inc_res;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_INIT;
            r_fill_addr  <= '0;
            r_fill_wr    <= 1'b0;
            r_fill_waddr <= '0;
            r_init_done  <= 1'b0;
            r_pv         <= '0;
            r_pa         <= '0;
            r_pi         <= '0;
            r_pc         <= '0;
            r_hv         <= '0;
            r_ha         <= '0;
            r_hd         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_fill_wr <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_fill_wr    <= 1'b1;
                    r_fill_waddr <= r_fill_addr;
                    r_fill_addr  <= r_fill_addr + 1'b1;
                    if (r_fill_addr == c_last_addr) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    // Rises one cycle after the last fill write is on the port.
                    r_init_done <= 1'b1;
                end
            endcase

            r_pv <= {r_pv[1:0], w_accept};
            r_pa <= {r_pa[1:0], req_addr};
            r_pi <= {r_pi[1:0], req_inc};
            r_pc <= {r_pc[1:0], req_clr};

            r_hv <= {r_hv[c_hist-2:0], r_pv[2]};
            r_ha <= {r_ha[c_hist-2:0], r_pa[2]};
            r_hd <= {r_hd[c_hist-2:0], w_new};

            r_rsp_valid <= r_pv[2];
            if (r_pv[2]) begin
                r_rsp_data <= w_base;
            end
        end
    end

    // The memory's fixed read latency must keep the ack aligned with C3.
    a_ack_align : assert property (@(posedge clk) disable iff (!rstn)
                                   app_mem_ack == r_pv[2]);

endmodule
`default_nettype wire

// File: tb/tb_wmem_stat_upd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wmem_stat_upd
//  Purpose  : Self-checking bench for wmem_stat_upd with a behavioural
//             memory (3-cycle read latency) and a per-entry counter model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wmem_stat_upd;

    localparam int WIDTH       = 40;
    localparam int DEPTH_NBITS = 4;
    localparam int INC_NBITS   = 16;
    localparam int DEPTH       = 1 << DEPTH_NBITS;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic                   clk;
    logic                   rstn;
    logic                   req_valid;
    logic                   req_ready;
    logic [DEPTH_NBITS-1:0] req_addr;
    logic [INC_NBITS-1:0]   req_inc;
    logic                   req_clr;
    logic                   rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic                   app_mem_rd;
    logic [DEPTH_NBITS-1:0] app_mem_raddr;
    logic                   app_mem_ack;
    logic [WIDTH-1:0]       app_mem_rdata;
    logic                   app_mem_wr;
    logic [DEPTH_NBITS-1:0] app_mem_waddr;
    logic [WIDTH-1:0]       app_mem_wdata;
    logic                   init_done;

    wmem_stat_upd #(
        .WIDTH       (WIDTH),
        .DEPTH_NBITS (DEPTH_NBITS),
        .INC_NBITS   (INC_NBITS)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_inc       (req_inc),
        .req_clr       (req_clr),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .app_mem_rd    (app_mem_rd),
        .app_mem_raddr (app_mem_raddr),
        .app_mem_ack   (app_mem_ack),
        .app_mem_rdata (app_mem_rdata),
        .app_mem_wr    (app_mem_wr),
        .app_mem_waddr (app_mem_waddr),
        .app_mem_wdata (app_mem_wdata),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ---------------- memory model ----------------
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [2:0]             rd_v;
    logic [WIDTH-1:0]       rd_d [3];
    logic                   poke_en;
    logic [DEPTH_NBITS-1:0] poke_addr;
    logic [WIDTH-1:0]       poke_data;

    always @(posedge clk) begin
        if (!rstn) rd_v <= '0;
        else       rd_v <= {rd_v[1:0], app_mem_rd};
        rd_d[0] <= mem[app_mem_raddr];
        rd_d[1] <= rd_d[0];
        rd_d[2] <= rd_d[1];
        if (app_mem_wr)   mem[app_mem_waddr] <= app_mem_wdata;
        else if (poke_en) mem[poke_addr]     <= poke_data;
    end
    assign app_mem_ack   = rd_v[2];
    assign app_mem_rdata = rd_d[2];

    // ---------------- events and reference model ----------------
    typedef struct packed {
        logic [31:0]            cyc;
        logic                   wr;
        logic [DEPTH_NBITS-1:0] addr;
        logic [WIDTH-1:0]       wdata;
        logic                   rv;
        logic [WIDTH-1:0]       rdata;
    } ev_t;

    ev_t              exp_q[$];
    ev_t              obs_q[$];
    bit               mon_en;
    logic [WIDTH-1:0] ref_mem [DEPTH];

    always @(negedge clk) begin
        if (mon_en && (app_mem_wr || rsp_valid))
            obs_q.push_back({32'(cyc), app_mem_wr, app_mem_waddr, app_mem_wdata, rsp_valid, rsp_data});
    end

    function automatic string ev_str(input ev_t e);
        return $sformatf("cyc=%0d wr=%b addr=%0d wdata=%h rsp_v=%b rsp=%h",
                         e.cyc, e.wr, e.addr, e.wdata, e.rv, e.rdata);
    endfunction

    // Counter arithmetic straight from the rules: clear, add, then wrap or clamp.
    function automatic logic [WIDTH-1:0] model_next(input logic [WIDTH-1:0] cur,
                                                   input logic [INC_NBITS-1:0] inc,
                                                   input bit clr);
        longint unsigned s;
        longint unsigned lim;
        lim = 64'd1 << WIDTH;
        if (clr) return '0;
        s = cur;
        s = s + inc;
`ifdef WMEM_STAT_SAT_EN
        if (s >= lim) return MAXV;
`else
        if (s >= lim) s = s - lim;
`endif
        return WIDTH'(s);
    endfunction

    task automatic send(input logic [DEPTH_NBITS-1:0] a, input logic [INC_NBITS-1:0] inc, input bit clr);
        logic [WIDTH-1:0] nxt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_inc = inc; req_clr = clr;
        nxt = model_next(ref_mem[a], inc, clr);
        exp_q.push_back({32'(cyc + 4), 1'b1, a, nxt, 1'b1, ref_mem[a]});
        ref_mem[a] = nxt;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req_valid = 1'b0; req_clr = 1'b0;
            req_addr = DEPTH_NBITS'($urandom); req_inc = INC_NBITS'($urandom);
        end
    endtask

    task automatic poke(input logic [DEPTH_NBITS-1:0] a, input logic [WIDTH-1:0] d);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [WIDTH+DEPTH_NBITS+5:0] obs, exp;
        int t0;
        rstn = 1'b0;
        for (int i = 0; i < DEPTH; i++) poke(DEPTH_NBITS'(i), {$urandom, $urandom});
        @(negedge clk);
        checks++;
        if ({req_ready, init_done, rsp_valid, rsp_data, app_mem_rd, app_mem_wr,
             app_mem_raddr, app_mem_waddr, app_mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_values: rdy=%b done=%b rv=%b rsp=%h rd=%b wr=%b ra=%0d wa=%0d wd=%h, required all zero",
                     req_ready, init_done, rsp_valid, rsp_data, app_mem_rd, app_mem_wr,
                     app_mem_raddr, app_mem_waddr, app_mem_wdata);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            req_valid = (k == 5); req_addr = 3; req_inc = 1; req_clr = 1'b0;
            @(negedge clk);
            // {wr, waddr, wdata, init_done, req_ready, rd, rsp_valid}
            exp = {(k <= 16), (k <= 16) ? DEPTH_NBITS'(k - 1) : app_mem_waddr,
                   (k <= 16) ? '0 : app_mem_wdata, (k >= 17), (k >= 17), 1'b0, 1'b0};
            obs = {app_mem_wr, app_mem_waddr, app_mem_wdata, init_done, req_ready, app_mem_rd, rsp_valid};
            checks++;
            if (obs !== exp || cyc != t0 + k) begin
                failures++;
                $display("FAIL init_cycle%0d: got wr=%b wa=%0d wd=%h done=%b rdy=%b rd=%b rv=%b, required %h",
                         k, app_mem_wr, app_mem_waddr, app_mem_wdata, init_done, req_ready,
                         app_mem_rd, rsp_valid, exp);
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            checks++;
            if (mem[i] !== '0) begin
                failures++;
                $display("FAIL init_fill[%0d]: got %h, required 0", i, mem[i]);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single;
        send(3, 5, 0); idle(10); send(3, 7, 0); idle(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL single_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL single_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (mem[3] !== 40'd12) begin failures++; $display("FAIL single_final: got %0d required 12", mem[3]); end
    endtask

    task automatic test_back_to_back;
        repeat (4) send(9, 1, 0);
        idle(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL b2b_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (mem[9] !== 40'd4) begin failures++; $display("FAIL b2b_final: got %0d required 4", mem[9]); end
    endtask

    task automatic test_spacing;
        for (int g = 1; g <= 5; g++) begin
            send(DEPTH_NBITS'(10 + g), 2, 0);
            if (g > 1) idle(g - 1);
            send(DEPTH_NBITS'(10 + g), 3, 0);
        end
        idle(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL spacing_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL spacing_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        exp_q.delete(); obs_q.delete();
        for (int g = 1; g <= 5; g++) begin
            checks++;
            if (mem[10 + g] !== 40'd5) begin
                failures++; $display("FAIL spacing_gap%0d: got %0d required 5", g, mem[10 + g]);
            end
        end
    endtask

    task automatic test_clear;
        send(7, 100, 0); idle(6);
        send(7, 0, 1); send(7, 4, 0); idle(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL clear_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL clear_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (mem[7] !== 40'd4) begin failures++; $display("FAIL clear_final: got %0d required 4", mem[7]); end
    endtask

    task automatic test_overflow;
        logic [WIDTH-1:0] want;
        poke(2, MAXV - 1);
        ref_mem[2] = MAXV - 1;
        idle(2);
        send(2, 5, 0); idle(8);
`ifdef WMEM_STAT_SAT_EN
        want = MAXV;
`else
        want = 40'd3;
`endif
        checks++;
        if (mem[2] !== want) begin failures++; $display("FAIL overflow_final: got %h required %h", mem[2], want); end
        send(2, 1, 0); send(2, 9, 0); idle(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL overflow_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL overflow_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random;
        poke(0, MAXV - 40'd70000);
        ref_mem[0] = MAXV - 40'd70000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 7)
                send(($urandom_range(0, 1) == 0) ? DEPTH_NBITS'($urandom_range(0, 2)) : DEPTH_NBITS'($urandom),
                     INC_NBITS'($urandom), ($urandom_range(0, 9) == 0));
            else
                idle(1);
        end
        idle(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL random_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL random_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                failures++; $display("FAIL random_mem[%0d]: got %h required %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; mon_en = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_inc = '0; req_clr = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_spacing();
        test_clear();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
